wb_led_pwm: RTL and testbench

WB_LED_PWM -- requirements
Module: wb_led_pwm

---
 rtl/wb_led_pkg.sv | 32 +++
 rtl/wb_led_pwm_chan.sv | 44 ++++
 rtl/wb_led_pwm.sv | 175 +++++++++++++++++
 tb/tb_wb_led_pwm.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_led_pkg.sv
// Shared encodings, register word indices and reset constants for the Wishbone LED PWM block.
package wb_led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_PWM    = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } led_mode_e;

  // Word indices (byte offset >> 2) within the 256-byte window
  localparam logic [5:0] WIDX_OUT      = 6'd0;
  localparam logic [5:0] WIDX_MODE     = 6'd1;
  localparam logic [5:0] WIDX_PRESCALE = 6'd2;
  localparam logic [5:0] WIDX_BLINK    = 6'd3;
  localparam logic [5:0] WIDX_DUTY0    = 6'd4;

  localparam logic [31:0] RST_REG   = 32'h0;
  localparam logic        RST_PHASE = 1'b0;

  function automatic logic [31:0] merge_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_led_pwm_chan.sv
// One LED channel: shadow duty (reloaded only at PWM wrap), PWM compare and mode mux feeding a registered output.
module wb_led_pwm_chan
  import wb_led_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wrap_i,
  input  logic [PWM_WIDTH-1:0] duty_i,
  input  logic [PWM_WIDTH-1:0] cnt_i,
  input  logic [1:0]           mode_i,
  input  logic                 out_i,
  input  logic                 phase_i,
  output logic                 led_o
);

  logic [PWM_WIDTH-1:0] shadow_q, shadow_d;
  logic                 led_q, led_d;

  always_comb begin
    shadow_d = wrap_i ? duty_i : shadow_q;
    led_d    = 1'b0;
    case (led_mode_e'(mode_i))
      MODE_STATIC: led_d = out_i;
      MODE_PWM:    led_d = (cnt_i < shadow_q);
      MODE_BLINK:  led_d = out_i & phase_i;
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/wb_led_pwm.sv
// Wishbone-controlled LED driver with static, PWM, blink and off modes per channel.
// Blink support is compiled in only when WB_LED_PWM_BLINK_EN is defined; otherwise blink mode behaves as static.
module wb_led_pwm
  import wb_led_pkg::*;
#(
  parameter int          NUM_LEDS  = 8,
  parameter int          PWM_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [NUM_LEDS-1:0] leds_o
);

  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  abandon_q, abandon_d;
  logic [NUM_LEDS-1:0]   out_q, out_d;
  logic [2*NUM_LEDS-1:0] mode_q, mode_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [PWM_WIDTH-1:0]  duty_q [NUM_LEDS];
  logic [PWM_WIDTH-1:0]  duty_d [NUM_LEDS];
  logic [15:0]           presc_cnt_q, presc_cnt_d;
  logic [PWM_WIDTH-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                  req, wr, tick, wrap, phase;
  logic [5:0]            widx;
  logic [31:0]           rdata, blink_rd;
  logic                  unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // A cycle already open when reset hit is ignored until the master drops cyc
  always_comb begin
    req  = wbs_stb_i & wbs_cyc_i & ~ack_q & ~abandon_q &
           (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    wr   = req & wbs_we_i;
    widx = wbs_adr_i[7:2];
  end

  always_comb begin
    rdata = '0;
    case (widx)
      WIDX_OUT:      rdata = 32'(out_q);
      WIDX_MODE:     rdata = 32'(mode_q);
      WIDX_PRESCALE: rdata = 32'(prescale_q);
      WIDX_BLINK:    rdata = blink_rd;
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (widx == 6'(WIDX_DUTY0 + i)) rdata = 32'(duty_q[i]);
        end
      end
    endcase
    ack_d     = req;
    dat_d     = (req && !wbs_we_i) ? rdata : '0;
    abandon_d = abandon_q & wbs_cyc_i;
  end

  always_comb begin
    out_d      = out_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (wr) begin
      if (widx == WIDX_OUT)
        out_d = NUM_LEDS'(merge_sel(32'(out_q), wbs_dat_i, wbs_sel_i));
      if (widx == WIDX_MODE)
        mode_d = (2*NUM_LEDS)'(merge_sel(32'(mode_q), wbs_dat_i, wbs_sel_i));
      if (widx == WIDX_PRESCALE)
        prescale_d = 16'(merge_sel(32'(prescale_q), wbs_dat_i, wbs_sel_i));
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (widx == 6'(WIDX_DUTY0 + i))
          duty_d[i] = PWM_WIDTH'(merge_sel(32'(duty_q[i]), wbs_dat_i, wbs_sel_i));
      end
    end
  end

  always_comb begin
    tick        = (presc_cnt_q == prescale_q);
    wrap        = tick && (pwm_cnt_q == {PWM_WIDTH{1'b1}});
    presc_cnt_d = tick ? '0 : presc_cnt_q + 16'd1;
    if (wr && widx == WIDX_PRESCALE) presc_cnt_d = '0;
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_WIDTH'(1) : pwm_cnt_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= RST_REG;
      abandon_q   <= 1'b1;
      out_q       <= '0;
      mode_q      <= '0;
      prescale_q  <= '0;
      duty_q      <= '{default: '0};
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      abandon_q   <= abandon_d;
      out_q       <= out_d;
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      duty_q      <= duty_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

`ifdef WB_LED_PWM_BLINK_EN
  logic [7:0] blink_half_q, blink_half_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  always_comb begin
    blink_half_d  = blink_half_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr && widx == WIDX_BLINK)
      blink_half_d = 8'(merge_sel(32'(blink_half_q), wbs_dat_i, wbs_sel_i));
    if (tick) begin
      if (blink_cnt_q == blink_half_q) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      blink_half_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= RST_PHASE;
    end else begin
      blink_half_q  <= blink_half_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign phase    = blink_phase_q;
  assign blink_rd = 32'(blink_half_q);
`else
  // Phase held high so blink mode collapses to the static OUT value
  assign phase    = 1'b1;
  assign blink_rd = '0;
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    wb_led_pwm_chan #(.PWM_WIDTH(PWM_WIDTH)) u_chan (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .wrap_i (wrap),
      .duty_i (duty_q[i]),
      .cnt_i  (pwm_cnt_q),
      .mode_i (mode_q[2*i +: 2]),
      .out_i  (out_q[i]),
      .phase_i(phase),
      .led_o  (leds_o[i])
    );
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_led_pwm.sv
// Bench for wb_led_pwm: cycle-accurate reference model from the register/PWM rules, per-cycle compare, directed and random bus traffic.
`timescale 1ns/1ps
module tb_wb_led_pwm;
  localparam int          NL   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat, rdat;
  logic          ack;
  logic [NL-1:0] leds;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_led_pwm #(.NUM_LEDS(NL), .PWM_WIDTH(8), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .leds_o   (leds)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0]   m_out, m_pre;
  logic [31:0]   m_mode, m_dat;
  logic [7:0]    m_duty [NL];
  logic [7:0]    m_shadow [NL];
  int            m_pc, m_cnt;
  logic          m_ack, m_abn;
  logic [NL-1:0] m_leds;
`ifdef WB_LED_PWM_BLINK_EN
  logic [7:0]    m_bh;
  int            m_bc;
  logic          m_phase;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] m_read(input int w);
    if (w == 0) return {16'h0, m_out};
    if (w == 1) return m_mode;
    if (w == 2) return {16'h0, m_pre};
`ifdef WB_LED_PWM_BLINK_EN
    if (w == 3) return {24'h0, m_bh};
`endif
    if (w >= 4 && w < 4 + NL) return {24'h0, m_duty[w-4]};
    return 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic          req, tick, wrap;
    logic [NL-1:0] nl;
    logic [31:0]   mv, rd;
    logic [1:0]    md;
    int            w;
    if (rst) begin
      m_out = '0; m_pre = '0; m_mode = '0; m_dat = '0;
      for (int i = 0; i < NL; i++) begin m_duty[i] = '0; m_shadow[i] = '0; end
      m_pc = 0; m_cnt = 0; m_ack = 1'b0; m_abn = 1'b1; m_leds = '0;
`ifdef WB_LED_PWM_BLINK_EN
      m_bh = '0; m_bc = 0; m_phase = 1'b0;
`endif
    end else begin
      w   = int'(adr[7:2]);
      req = stb && cyc && (adr[31:8] == BASE[31:8]) && !m_ack && !m_abn;
      rd  = m_read(w);
      for (int i = 0; i < NL; i++) begin
        md = m_mode[2*i +: 2];
        case (md)
          2'd0: nl[i] = m_out[i];
          2'd1: nl[i] = (m_cnt < int'(m_shadow[i]));
`ifdef WB_LED_PWM_BLINK_EN
          2'd2: nl[i] = m_out[i] & m_phase;
`else
          2'd2: nl[i] = m_out[i];
`endif
          default: nl[i] = 1'b0;
        endcase
      end
      tick = (m_pc == int'(m_pre));
      wrap = tick && (m_cnt == 255);
      if (wrap) for (int i = 0; i < NL; i++) m_shadow[i] = m_duty[i];
      m_pc = tick ? 0 : m_pc + 1;
      if (tick) m_cnt = (m_cnt + 1) % 256;
`ifdef WB_LED_PWM_BLINK_EN
      if (tick) begin
        if (m_bc == int'(m_bh)) begin m_bc = 0; m_phase = !m_phase; end
        else m_bc++;
      end
`endif
      if (req && we) begin
        mv = merge(m_read(w), wdat, sel);
        if (w == 0) m_out = mv[15:0];
        if (w == 1) m_mode = mv;
        if (w == 2) begin m_pre = mv[15:0]; m_pc = 0; end
`ifdef WB_LED_PWM_BLINK_EN
        if (w == 3) m_bh = mv[7:0];
`endif
        if (w >= 4 && w < 4 + NL) m_duty[w-4] = mv[7:0];
      end
      m_ack  = req;
      m_dat  = (req && !we) ? rd : 32'h0;
      m_leds = nl;
      m_abn  = m_abn & cyc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("leds_model", {16'h0, leds}, {16'h0, m_leds});
      check("ack_model", {31'h0, ack}, {31'h0, m_ack});
      if (m_ack) check("rdata_model", rdat, m_dat);
    end
  end

  // ---------------- bus helpers ----------------
  logic          b_got, b_ack_after;
  logic [31:0]   b_rd;
  logic [NL-1:0] b_led_ack, b_led_after;

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    b_got = 1'b0; b_rd = '0; b_led_ack = '0;
    for (int k = 0; k < 4 && !b_got; k++) begin
      @(negedge clk);
      if (ack) begin b_got = 1'b1; b_rd = rdat; b_led_ack = leds; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    b_ack_after = ack;
    b_led_after = leds;
    if (b_got) check("ack_single_cycle", {31'h0, b_ack_after}, 32'h0);
  endtask

  task automatic wait_rise(input int bi, input int limit, output bit ok);
    logic prev;
    prev = leds[bi];
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (leds[bi] && !prev) begin ok = 1'b1; break; end
      prev = leds[bi];
    end
  endtask

  task automatic run_len(input int bi, input int limit, output int n);
    n = 1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (leds[bi]) n++;
      else break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          ok, hit;
    int          n, cnt, kind;
    logic [31:0] a, d;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    check("leds_after_reset", {16'h0, leds}, 32'h0);
    bus(BASE + 32'h00, 1'b0, 0, 4'hF);
    check("rd_out_reset", b_rd, 32'h0);
    bus(BASE + 32'h04, 1'b0, 0, 4'hF);
    check("rd_mode_reset", b_rd, 32'h0);

    // static OUT write: leds change one edge after the ack cycle
    bus(BASE + 32'h00, 1'b1, 32'hA5, 4'hF);
    check("wr_out_ack", {31'h0, b_got}, 32'h1);
    check("leds_during_ack", {16'h0, b_led_ack}, 32'h0);
    check("leds_static_a5", {16'h0, b_led_after}, 32'hA5);
    bus(BASE + 32'h00, 1'b0, 0, 4'hF);
    check("rd_out_a5", b_rd, 32'hA5);

    bus(BASE + 32'h00, 1'b1, 32'hFFFF, 4'b0001);
    bus(BASE + 32'h00, 1'b0, 0, 4'hF);
    check("rd_out_sel0001", b_rd, 32'h00FF);
    bus(BASE + 32'h0C0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    check("wr_unmapped_ack", {31'h0, b_got}, 32'h1);
    bus(BASE + 32'h0C0, 1'b0, 0, 4'hF);
    check("rd_unmapped_ack", {31'h0, b_got}, 32'h1);
    check("rd_unmapped_data", b_rd, 32'h0);
    bus(BASE + 32'h50, 1'b0, 0, 4'hF);
    check("rd_duty16_data", b_rd, 32'h0);
    bus(BASE + 32'h00, 1'b0, 0, 4'hF);
    check("rd_out_unchanged", b_rd, 32'h00FF);
    bus(BASE + 32'h100, 1'b0, 0, 4'hF);
    check("foreign_no_ack", {31'h0, b_got}, 32'h0);

    // PWM on LED0: duty 64, then 200 written mid-period
    bus(BASE + 32'h08, 1'b1, 0, 4'hF);
    bus(BASE + 32'h10, 1'b1, 64, 4'hF);
    bus(BASE + 32'h04, 1'b1, 32'h1, 4'hF);
    wait_rise(0, 600, ok);
    check("pwm_rise_64", {31'h0, ok}, 32'h1);
    fork
      run_len(0, 300, n);
      begin repeat (10) @(negedge clk); bus(BASE + 32'h10, 1'b1, 200, 4'hF); end
    join
    check("pwm_high_64", n, 64);
    wait_rise(0, 600, ok);
    check("pwm_rise_200", {31'h0, ok}, 32'h1);
    run_len(0, 300, n);
    check("pwm_high_200", n, 200);

    // duty all-ones on LED2, duty 0 on LED3
    bus(BASE + 32'h18, 1'b1, 255, 4'hF);
    bus(BASE + 32'h1C, 1'b1, 0, 4'hF);
    bus(BASE + 32'h04, 1'b1, 32'h51, 4'hF);
    repeat (520) @(negedge clk);
    n = 0; cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (!leds[2]) n++;
      if (leds[3]) cnt++;
    end
    check("pwm_full_lows", n, 1);
    check("pwm_zero_highs", cnt, 0);

    // blink on LED1 with OUT[1]=1
    bus(BASE + 32'h08, 1'b1, 1, 4'hF);
    bus(BASE + 32'h0C, 1'b1, 3, 4'hF);
    bus(BASE + 32'h0C, 1'b0, 0, 4'hF);
`ifdef WB_LED_PWM_BLINK_EN
    check("rd_blink_half", b_rd, 32'h3);
`else
    check("rd_blink_half", b_rd, 32'h0);
`endif
    bus(BASE + 32'h04, 1'b1, 32'h59, 4'hF);
`ifdef WB_LED_PWM_BLINK_EN
    wait_rise(1, 100, ok);
    check("blink_rise", {31'h0, ok}, 32'h1);
    run_len(1, 50, n);
    check("blink_half_period", n, 8);
`else
    cnt = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (leds[1]) cnt++; end
    check("blink_disabled_static", cnt, 40);
`endif

    // random traffic against the model
    for (int op = 0; op < 400; op++) begin
      kind = $urandom_range(0, 11);
      if (kind == 0) a = BASE + 32'h0C0;
      else if (kind == 1) a = BASE + 32'h100 + 4 * $urandom_range(0, 7);
      else a = BASE + 4 * $urandom_range(0, 4 + NL + 1);
      d = $urandom;
      if (a[7:2] == 6'd2) d[15:0] = 16'($urandom_range(0, 3));
      if (a[7:2] == 6'd3) d[15:0] = 16'($urandom_range(0, 5));
      hit = (a[31:8] == BASE[31:8]);
      bus(a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)));
      check("ack_rand", {31'h0, b_got}, {31'h0, hit});
      repeat ($urandom_range(0, 12)) @(negedge clk);
      if (op % 50 == 49) repeat (300) @(negedge clk);
    end

    // reset in the middle of a read
    bus(BASE + 32'h00, 1'b1, 32'hFF, 4'hF);
    bus(BASE + 32'h04, 1'b1, 32'h0, 4'hF);
    check("leds_before_rst", {16'h0, b_led_after}, 32'hFF);
    @(negedge clk);
    adr = BASE; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    check("ack_in_reset", {31'h0, ack}, 32'h0);
    check("leds_in_reset", {16'h0, leds}, 32'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ack_abandoned", {31'h0, ack}, 32'h0);
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 4 + NL; w++) begin
      bus(BASE + 32'(4 * w), 1'b0, 0, 4'hF);
      check("rd_after_reset", b_rd, 32'h0);
    end
    check("leds_after_rst", {16'h0, leds}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
